bank_req_data_path: RTL and testbench
=====================================

# bank_req_data_path

Registered, flow-controlled request data path for the back-end arbiter. It selects one request word from a flattened array of `GROUPS × BANKS` bank-queue heads, using a group index plus a per-group bank index. The selected word goes into a 2-entry output skid buffer with valid/ready on both sides. In the same cycle it issues a one-hot pop back to the chosen bank queue. It sits between the bank/group arbiter (producer of selects) and the command/data scheduler (consumer).

## Interface
- `REQ_SIZE`, 32, width of one request word
- `GROUPS`, 4, number of bank groups (≥1)
- `BANKS`, 4, banks per group (≥1)
- `GW`, `$clog2(GROUPS)` (min 1), group index width (derived)
- `BW`, `$clog2(BANKS)` (min 1), bank index width (derived)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `data` in `REQ_SIZE*GROUPS*BANKS`: queue heads; entry (g,b) at `[(g*BANKS+b)*REQ_SIZE +: REQ_SIZE]`
- `sel_valid` in 1: select request present
- `sel_ready` out 1: block can accept a select
- `group_sel` in `GW`: selected group
- `bank_sel` in `GROUPS*BW`: bank index for group g at `[g*BW +: BW]`
- `pop` out `GROUPS*BANKS`: one-hot, bit g*BANKS+b, dequeue strobe to bank queue
- `sel_err` out 1: one-cycle pulse, out-of-range select consumed
- `out_valid` out 1: output word valid
- `out_ready` in 1: consumer accepts
- `out` out `REQ_SIZE`: selected request word
- `out_group` out `GW`: group of `out`
- `out_bank` out `BW`: bank of `out`

## Operation
- Accept: `acc = sel_valid & sel_ready`. In an accept cycle, g = `group_sel` and b = `bank_sel[g*BW +: BW]`.
- In-range (g<GROUPS, b<BANKS):
  - push {data(g,b), g, b} into the skid buffer;
  - `pop[g*BANKS+b]` = 1, combinational, same cycle as `acc`.
- Out-of-range:
  - request consumed, no push, `pop` = 0;
  - `sel_err` = 1 in the following cycle (registered).
- `pop` is all-zero whenever `acc` = 0.
- Skid buffer: 2-entry FIFO with `count` ∈ {0,1,2}.
  - `sel_ready = (count != 2)`.
  - `out_valid = (count != 0)`.
  - `out`/`out_group`/`out_bank` are driven from the head entry, straight from registers.
- Consume: `deq = out_valid & out_ready`.
- Push and dequeue in the same cycle:
  - count unchanged;
  - the head advances;
  - the new entry is written behind the old second entry, or becomes the head if count was 1.
- Count update: `count += push - deq`.
- Payload stability: the head payload holds stable while `out_valid & !out_ready`.
- Writes only on push.

## Timing
- Reset: `count`=0, `out_valid`=0, `sel_err`=0, `out`/`out_group`/`out_bank`=0, `pop`=0, `sel_ready`=1 in the first cycle after reset.
- Latency: a select accepted at cycle N appears at `out` with `out_valid`=1 in cycle N+1, when the buffer was empty or deq occurred at N.
- Throughput: 1 word/cycle while `out_ready`=1 (count stays ≤1).
- Backpressure: with `out_ready`=0, two accepts fill the buffer and `sel_ready` drops in the next cycle. With count=2, `sel_ready` stays 0 even if `out_ready`=1 this cycle; it reasserts the cycle after the dequeue.
- Select hold: `sel_valid` with `sel_ready`=0 has no effect. No pop; indices must be held by the producer.
- Reset mid-operation: buffered entries are discarded, with no pop and no out_valid in the following cycle.

## Structure
- Shared package `arb_pkg`:
  - function `flat_idx(g,b,BANKS)`;
  - typedef for the buffer entry struct {data, group, bank}, parameterised through the module.
- Sub-module `req_skid_buf` (2-entry valid/ready FIFO, payload width parameter). Selection and pop decode stay in the top module.

## Test plan
- Reset, then idle: after `rst`, `sel_ready`=1, `out_valid`=0, `pop`=0, `out`=0.
- Single select (defaults):
  - stimulus: data(2,3)=0xC0DE_0023, `group_sel`=2, `bank_sel[5:4]`=3, `sel_valid` one cycle, `out_ready`=1;
  - response: `pop` bit 11 high in the accept cycle; next cycle `out`=0xC0DE_0023, `out_group`=2, `out_bank`=3, `out_valid`=1.
- Streaming: 16 back-to-back selects sweeping all (g,b) with `out_ready`=1 → 16 consecutive outputs in order, `sel_ready` never low, each `pop` bit pulsed exactly once.
- Backpressure:
  - stimulus: `out_ready`=0, 3 selects offered;
  - response: 2 accepted; `sel_ready`=0 from the third cycle; third held; after `out_ready`=1, outputs come in order with no loss or duplication.
- Out-of-range (GROUPS=3, BANKS=4):
  - stimulus: `group_sel`=3;
  - response: accepted, `pop`=0, `sel_err` pulses next cycle, `out_valid` stays 0.
- Reset mid-flight: buffer count=2, assert `rst` → next cycle `out_valid`=0, `sel_ready`=1, no spurious `pop`.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the back-end arbiter request path.
// Contents:
//   flat_idx  - maps a (group, bank) pair onto the flattened queue-head /
//               pop-vector index g*BANKS+b.
// The buffer entry struct depends on the module's width parameters, so each
// user declares it locally as {data, group, bank}.
package arb_pkg;

    localparam int REQ_SIZE_DEFAULT = 32;
    localparam int GROUPS_DEFAULT   = 4;
    localparam int BANKS_DEFAULT    = 4;

    function automatic int flat_idx(input int g, input int b, input int banks);
        return g * banks + b;
    endfunction

endpackage

// File: rtl/req_skid_buf.sv
// Two-entry valid/ready FIFO used as the registered output stage of the
// request data path.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid / in_ready - write side; in_ready is low only when both entries are full
//   in_data  [W]        - entry written on in_valid & in_ready
//   out_valid/out_ready - read side; out_valid is high whenever an entry is held
//   out_data [W]        - head entry, driven directly from a register
module req_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         deq;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, deq};
            if (deq) begin
                // Head advances; a simultaneous push lands behind whatever
                // remains, which is the head slot when only one entry was held.
                if (count == 2'd2) begin
                    head <= tail;
                end
                if (push) begin
                    if (count == 2'd2) begin
                        tail <= in_data;
                    end else begin
                        head <= in_data;
                    end
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head <= in_data;
                end else begin
                    tail <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/bank_req_data_path.sv
// Request data path between the bank/group arbiter and the command/data
// scheduler. Picks one queue-head word by (group, per-group bank) select,
// strobes a one-hot pop back to that bank queue in the accept cycle and
// registers {word, group, bank} into a 2-entry output skid buffer.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   data      [R*G*B]      - queue heads, entry (g,b) at (g*BANKS+b)*REQ_SIZE
//   sel_valid / sel_ready  - select handshake from the arbiter
//   group_sel [GW]         - selected group
//   bank_sel  [G*BW]       - bank index per group, group g at g*BW
//   pop       [G*B]        - one-hot dequeue strobe, combinational with accept
//   sel_err                - one-cycle pulse after an out-of-range select is consumed
//   out_valid / out_ready  - output handshake to the scheduler
//   out, out_group, out_bank - head entry of the skid buffer
module bank_req_data_path
    import arb_pkg::*;
#(
    parameter int REQ_SIZE = REQ_SIZE_DEFAULT,
    parameter int GROUPS   = GROUPS_DEFAULT,
    parameter int BANKS    = BANKS_DEFAULT,
    parameter int GW       = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    parameter int BW       = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_SIZE*GROUPS*BANKS-1:0] data,
    input  logic                         sel_valid,
    output logic                         sel_ready,
    input  logic [GW-1:0]                group_sel,
    input  logic [GROUPS*BW-1:0]         bank_sel,
    output logic [GROUPS*BANKS-1:0]      pop,
    output logic                         sel_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REQ_SIZE-1:0]          out,
    output logic [GW-1:0]                out_group,
    output logic [BW-1:0]                out_bank
);

    typedef struct packed {
        logic [REQ_SIZE-1:0] data;
        logic [GW-1:0]       group;
        logic [BW-1:0]       bank;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic                acc;
    logic                in_range;
    logic                group_ok;
    logic                bank_ok;
    logic [BW-1:0]       bank_idx;
    logic [REQ_SIZE-1:0] word;
    entry_t              push_entry;
    entry_t              head_entry;

    assign acc = sel_valid & sel_ready;

    // Range checks are done by matching against each legal index rather than
    // by magnitude compares, so non-power-of-two GROUPS/BANKS need no special case.
    always_comb begin
        group_ok = 1'b0;
        bank_ok  = 1'b0;
        bank_idx = '0;
        word     = '0;
        pop      = '0;
        for (int gi = 0; gi < GROUPS; gi++) begin
            if (group_sel == GW'(gi)) begin
                group_ok = 1'b1;
                bank_idx = bank_sel[gi*BW +: BW];
            end
        end
        for (int bi = 0; bi < BANKS; bi++) begin
            if (bank_idx == BW'(bi)) begin
                bank_ok = 1'b1;
            end
        end
        for (int gi = 0; gi < GROUPS; gi++) begin
            for (int bi = 0; bi < BANKS; bi++) begin
                if (group_sel == GW'(gi) && bank_idx == BW'(bi)) begin
                    word = data[flat_idx(gi, bi, BANKS)*REQ_SIZE +: REQ_SIZE];
                    pop[flat_idx(gi, bi, BANKS)] = acc;
                end
            end
        end
        in_range = group_ok & bank_ok;
    end

    assign push_entry.data  = word;
    assign push_entry.group = group_sel;
    assign push_entry.bank  = bank_idx;

    req_skid_buf #(
        .W(EW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc & in_range),
        .in_ready  (sel_ready),
        .in_data   (push_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_entry)
    );

    assign out       = head_entry.data;
    assign out_group = head_entry.group;
    assign out_bank  = head_entry.bank;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= acc & ~in_range;
        end
    end

endmodule

// File: tb/tb_bank_req_data_path.sv
module tb_bank_req_data_path;

    localparam int RS = 32;
    localparam int G  = 4;
    localparam int B  = 4;
    localparam int G3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [RS*G*B-1:0] data;
    logic              sel_valid;
    logic              sel_ready;
    logic [1:0]        group_sel;
    logic [G*2-1:0]    bank_sel;
    logic [G*B-1:0]    pop;
    logic              sel_err;
    logic              out_valid;
    logic              out_ready;
    logic [RS-1:0]     out;
    logic [1:0]        out_group;
    logic [1:0]        out_bank;

    logic [RS*G3*B-1:0] data3;
    logic               sel_valid3;
    logic               sel_ready3;
    logic [1:0]         group_sel3;
    logic [G3*2-1:0]    bank_sel3;
    logic [G3*B-1:0]    pop3;
    logic               sel_err3;
    logic               out_valid3;
    logic               out_ready3;
    logic [RS-1:0]      out3;
    logic [1:0]         out_group3;
    logic [1:0]         out_bank3;

    bank_req_data_path #(.REQ_SIZE(RS), .GROUPS(G), .BANKS(B)) dut (
        .clk(clk), .rst(rst), .data(data), .sel_valid(sel_valid), .sel_ready(sel_ready),
        .group_sel(group_sel), .bank_sel(bank_sel), .pop(pop), .sel_err(sel_err),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_group(out_group), .out_bank(out_bank)
    );

    bank_req_data_path #(.REQ_SIZE(RS), .GROUPS(G3), .BANKS(B)) dut3 (
        .clk(clk), .rst(rst), .data(data3), .sel_valid(sel_valid3), .sel_ready(sel_ready3),
        .group_sel(group_sel3), .bank_sel(bank_sel3), .pop(pop3), .sel_err(sel_err3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out(out3),
        .out_group(out_group3), .out_bank(out_bank3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the skid buffer is just an ordered list of accepted
    // requests, at most two long.
    typedef struct {
        logic [RS-1:0] d;
        int            g;
        int            b;
    } exp_t;

    exp_t           mq[$];
    logic           exp_ready;
    logic           exp_valid;
    logic           exp_acc;
    logic [G*B-1:0] exp_pop;
    exp_t           exp_head;

    function automatic int cur_bank();
        int g;
        g = int'(group_sel);
        return int'((bank_sel >> (g*2)) & 8'h3);
    endfunction

    function automatic void model_expect();
        int g;
        int b;
        g = int'(group_sel);
        b = cur_bank();
        exp_ready = (mq.size() < 2);
        exp_valid = (mq.size() != 0);
        if (exp_valid) exp_head = mq[0];
        exp_acc = sel_valid && exp_ready;
        exp_pop = exp_acc ? (16'h1 << (g*B + b)) : 16'h0;
    endfunction

    function automatic void model_advance();
        exp_t e;
        if (mq.size() != 0 && out_ready) mq.delete(0);
        if (exp_acc) begin
            e.g = int'(group_sel);
            e.b = cur_bank();
            e.d = data[(e.g*B + e.b)*RS +: RS];
            mq.push_back(e);
        end
    endfunction

    task automatic rand_data();
        for (int i = 0; i < G*B; i++) data[i*RS +: RS] = $urandom;
        for (int i = 0; i < G3*B; i++) data3[i*RS +: RS] = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel_valid = 1'b0; out_ready = 1'b0; group_sel = '0; bank_sel = '0;
        sel_valid3 = 1'b0; out_ready3 = 1'b0; group_sel3 = '0; bank_sel3 = '0;
        rand_data();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        @(negedge clk);
        n_tests++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sel_ready got %b want 1", sel_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (pop !== '0) begin n_fail++; $display("FAIL reset_pop got %h want 0", pop); end
        n_tests++; if (out !== '0 || out_group !== '0 || out_bank !== '0) begin
            n_fail++; $display("FAIL reset_out got %h/%0d/%0d want 0/0/0", out, out_group, out_bank); end
        n_tests++; if (sel_err !== 1'b0 || sel_err3 !== 1'b0) begin
            n_fail++; $display("FAIL reset_sel_err got %b/%b want 0/0", sel_err, sel_err3); end
        next_cycle();
    endtask

    task automatic test_single();
        rand_data();
        data[11*RS +: RS] = 32'hC0DE_0023;
        group_sel = 2'd2;
        bank_sel = 8'($urandom);
        bank_sel[5:4] = 2'd3;
        sel_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        model_expect();
        n_tests++; if (pop !== 16'h0800) begin n_fail++; $display("FAIL single_pop got %h want 0800", pop); end
        model_advance();
        next_cycle();
        sel_valid = 1'b0;
        @(negedge clk);
        model_expect();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        n_tests++; if (out !== 32'hC0DE_0023) begin n_fail++; $display("FAIL single_out got %h want c0de0023", out); end
        n_tests++; if (out_group !== 2'd2 || out_bank !== 2'd3) begin
            n_fail++; $display("FAIL single_gb got %0d/%0d want 2/3", out_group, out_bank); end
        n_tests++; if (pop !== '0) begin n_fail++; $display("FAIL single_pop_idle got %h want 0", pop); end
        model_advance();
        next_cycle();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", out_valid); end
        next_cycle();
    endtask

    task automatic test_streaming();
        logic [G*B-1:0] pop_seen;
        int pop_cnt;
        int n_out;
        pop_seen = '0; pop_cnt = 0; n_out = 0;
        out_ready = 1'b1;
        for (int k = 0; k <= G*B; k++) begin
            rand_data();
            sel_valid = (k < G*B);
            if (k < G*B) begin
                group_sel = 2'(k / B);
                bank_sel = 8'($urandom);
                bank_sel[(k/B)*2 +: 2] = 2'(k % B);
            end
            @(negedge clk);
            model_expect();
            n_tests++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL stream_sel_ready k=%0d got %b want 1", k, sel_ready); end
            n_tests++; if (pop !== exp_pop) begin n_fail++; $display("FAIL stream_pop k=%0d got %h want %h", k, pop, exp_pop); end
            n_tests++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL stream_out_valid k=%0d got %b want %b", k, out_valid, exp_valid); end
            if (exp_valid) begin
                n_tests++;
                if (out !== exp_head.d || int'(out_group) != exp_head.g || int'(out_bank) != exp_head.b
                    || int'(out_group)*B + int'(out_bank) != n_out) begin
                    n_fail++;
                    $display("FAIL stream_out k=%0d got %h/%0d/%0d want %h/%0d/%0d", k, out, out_group, out_bank,
                             exp_head.d, exp_head.g, exp_head.b);
                end
                n_out++;
            end
            pop_seen |= pop;
            pop_cnt += $countones(pop);
            model_advance();
            next_cycle();
        end
        sel_valid = 1'b0;
        n_tests++; if (pop_seen !== 16'hFFFF || pop_cnt != 16) begin
            n_fail++; $display("FAIL stream_pop_cover got %h/%0d want ffff/16", pop_seen, pop_cnt); end
        n_tests++; if (n_out != 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", n_out); end
    endtask

    task automatic test_backpressure();
        int s;
        int n_out;
        int gs[3];
        int bs[3];
        s = 0; n_out = 0;
        for (int i = 0; i < 3; i++) begin
            gs[i] = $urandom_range(0, G-1);
            bs[i] = $urandom_range(0, B-1);
        end
        sel_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rand_data();
            out_ready = (cyc >= 3);
            if (s < 3) begin
                group_sel = 2'(gs[s]);
                bank_sel = 8'($urandom);
                bank_sel[gs[s]*2 +: 2] = 2'(bs[s]);
            end
            sel_valid = (s < 3);
            @(negedge clk);
            model_expect();
            if (cyc == 2 || cyc == 3) begin
                n_tests++; if (sel_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full cyc=%0d got %b want 0", cyc, sel_ready); end
                n_tests++; if (pop !== '0) begin n_fail++; $display("FAIL bp_held_pop cyc=%0d got %h want 0", cyc, pop); end
            end
            n_tests++; if (sel_ready !== exp_ready) begin n_fail++; $display("FAIL bp_sel_ready cyc=%0d got %b want %b", cyc, sel_ready, exp_ready); end
            n_tests++; if (pop !== exp_pop) begin n_fail++; $display("FAIL bp_pop cyc=%0d got %h want %h", cyc, pop, exp_pop); end
            n_tests++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got %b want %b", cyc, out_valid, exp_valid); end
            if (exp_valid) begin
                n_tests++;
                if (out !== exp_head.d || int'(out_group) != exp_head.g || int'(out_bank) != exp_head.b) begin
                    n_fail++;
                    $display("FAIL bp_out cyc=%0d got %h/%0d/%0d want %h/%0d/%0d", cyc, out, out_group, out_bank,
                             exp_head.d, exp_head.g, exp_head.b);
                end
                if (out_ready) n_out++;
            end
            if (exp_acc) s++;
            model_advance();
            next_cycle();
        end
        sel_valid = 1'b0;
        n_tests++; if (n_out != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", n_out); end
    endtask

    task automatic test_out_of_range();
        rand_data();
        group_sel3 = 2'd3;
        bank_sel3 = 6'($urandom);
        sel_valid3 = 1'b1;
        out_ready3 = 1'b1;
        @(negedge clk);
        n_tests++; if (sel_ready3 !== 1'b1) begin n_fail++; $display("FAIL oor_sel_ready got %b want 1", sel_ready3); end
        n_tests++; if (pop3 !== '0) begin n_fail++; $display("FAIL oor_pop got %h want 0", pop3); end
        next_cycle();
        sel_valid3 = 1'b0;
        @(negedge clk);
        n_tests++; if (sel_err3 !== 1'b1) begin n_fail++; $display("FAIL oor_sel_err got %b want 1", sel_err3); end
        n_tests++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL oor_out_valid got %b want 0", out_valid3); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (sel_err3 !== 1'b0) begin n_fail++; $display("FAIL oor_sel_err_pulse got %b want 0", sel_err3); end
        next_cycle();
        group_sel3 = 2'd2;
        bank_sel3[5:4] = 2'd1;
        sel_valid3 = 1'b1;
        @(negedge clk);
        n_tests++; if (pop3 !== 12'h200) begin n_fail++; $display("FAIL g3_pop got %h want 200", pop3); end
        next_cycle();
        sel_valid3 = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid3 !== 1'b1 || out3 !== data3[9*RS +: RS] || out_group3 !== 2'd2 || out_bank3 !== 2'd1) begin
            n_fail++; $display("FAIL g3_out got %b/%h/%0d/%0d want 1/%h/2/1", out_valid3, out3, out_group3, out_bank3, data3[9*RS +: RS]); end
        n_tests++; if (sel_err3 !== 1'b0) begin n_fail++; $display("FAIL g3_sel_err got %b want 0", sel_err3); end
        next_cycle();
        out_ready3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        sel_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_data();
            group_sel = 2'($urandom);
            bank_sel = 8'($urandom);
            @(negedge clk);
            model_expect();
            n_tests++; if (pop !== exp_pop) begin n_fail++; $display("FAIL mid_fill_pop i=%0d got %h want %h", i, pop, exp_pop); end
            model_advance();
            next_cycle();
        end
        @(negedge clk);
        n_tests++; if (sel_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_full got %b/%b want 0/1", sel_ready, out_valid); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (pop !== '0) begin n_fail++; $display("FAIL mid_rst_pop got %h want 0", pop); end
        next_cycle();
        rst = 1'b0;
        sel_valid = 1'b0;
        mq.delete();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || sel_ready !== 1'b1 || pop !== '0) begin
            n_fail++; $display("FAIL mid_after got %b/%b/%h want 0/1/0", out_valid, sel_ready, pop); end
        next_cycle();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rand_data();
            sel_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6) || (cyc >= 390);
            if (cyc >= 385) sel_valid = 1'b0;
            group_sel = 2'($urandom);
            bank_sel = 8'($urandom);
            @(negedge clk);
            model_expect();
            n_tests++; if (sel_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_sel_ready cyc=%0d got %b want %b", cyc, sel_ready, exp_ready); end
            n_tests++; if (pop !== exp_pop) begin n_fail++; $display("FAIL rnd_pop cyc=%0d got %h want %h", cyc, pop, exp_pop); end
            n_tests++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_out_valid cyc=%0d got %b want %b", cyc, out_valid, exp_valid); end
            if (exp_valid) begin
                n_tests++;
                if (out !== exp_head.d || int'(out_group) != exp_head.g || int'(out_bank) != exp_head.b) begin
                    n_fail++;
                    $display("FAIL rnd_out cyc=%0d got %h/%0d/%0d want %h/%0d/%0d", cyc, out, out_group, out_bank,
                             exp_head.d, exp_head.g, exp_head.b);
                end
            end
            n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rnd_sel_err cyc=%0d got %b want 0", cyc, sel_err); end
            model_advance();
            next_cycle();
        end
        sel_valid = 1'b0;
        n_tests++; if (mq.size() != 0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain got %0d/%b want 0/0", mq.size(), out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
